// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input path: state encoding,
// index bit reversal and ADC-sample to fixed-point conversion.
package fft_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_SEND = 1'b1
   } fft_state_e;

   // Reverses the low nbits of idx; higher bits of idx are ignored.
   function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < nbits) begin
            r = (r << 1) | ((idx >> i) & 32'd1);
         end
      end
      return r;
   endfunction

   // Sample arrives already sign-extended; caller truncates to its word width.
   function automatic logic [63:0] fxp_from_sample(input logic signed [63:0] sample,
                                                   input int unsigned shift);
      return sample <<< shift;
   endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// N_SAMPLES x BIT_WIDTH register file: one synchronous write port,
// synchronous active-low clear, all words readable in parallel.
module fft_frame_buffer
   import fft_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8,
   parameter int ADDR_W    = 3
) (
   input  logic                 clk,
   input  logic                 i_clr_n,
   input  logic                 i_we,
   input  logic [ADDR_W-1:0]    i_waddr,
   input  logic [BIT_WIDTH-1:0] i_wdata,
   output logic [BIT_WIDTH-1:0] o_rdata [N_SAMPLES-1:0]
);

   logic [BIT_WIDTH-1:0] r_mem [N_SAMPLES-1:0];

   always_ff @(posedge clk) begin
      if (!i_clr_n) begin
         for (int i = 0; i < N_SAMPLES; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem;

endmodule

// File: rtl/fft_input_deserializer.sv
// Collects N_SAMPLES ADC samples into one frame for the first FFT stage.
// Define FFT_INPUT_BITREV_EN to store samples in bit-reversed (DIT) order.
module fft_input_deserializer
   import fft_pkg::*;
#(
   parameter int BIT_WIDTH   = 32,
   parameter int DECIMAL_PT  = 16,
   parameter int INPUT_WIDTH = 16,
   parameter int N_SAMPLES   = 8,
   localparam int CNT_W      = $clog2(N_SAMPLES)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [INPUT_WIDTH-1:0] recv_msg,
   input  logic                   recv_val,
   output logic                   recv_rdy,
   output logic [BIT_WIDTH-1:0]   send_msg_real [N_SAMPLES-1:0],
   output logic [BIT_WIDTH-1:0]   send_msg_imag [N_SAMPLES-1:0],
   output logic                   send_val,
   input  logic                   send_rdy,
   output logic                   o_dbg_state,
   output logic [CNT_W-1:0]       o_dbg_cnt
);

   localparam int unsigned SHIFT = DECIMAL_PT - (INPUT_WIDTH - 1);

   // Handshakes: a transfer happens on a rising edge where both val and rdy
   // are high; val never waits on rdy, and both rdy and val drop while reset is low.
   fft_state_e          r_state;
   fft_state_e          w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                w_recv_fire;
   logic [CNT_W-1:0]    w_waddr;
   logic signed [63:0]  w_ext;
   logic [BIT_WIDTH-1:0] w_conv;

   assign w_recv_fire = recv_val && recv_rdy;
   assign w_ext       = 64'(signed'(recv_msg));
   assign w_conv      = BIT_WIDTH'(fxp_from_sample(w_ext, SHIFT));

`ifdef FFT_INPUT_BITREV_EN
   assign w_waddr = CNT_W'(bitrev(32'(r_cnt), CNT_W));
`else
   assign w_waddr = r_cnt;
`endif

   always_comb begin
      w_next_state = r_state;
      recv_rdy     = 1'b0;
      send_val     = 1'b0;
      case (r_state)
         ST_FILL: begin
            recv_rdy = reset;
            if (w_recv_fire && (r_cnt == CNT_W'(N_SAMPLES - 1))) begin
               w_next_state = ST_SEND;
            end
         end
         ST_SEND: begin
            send_val = reset;
            if (send_rdy) begin
               w_next_state = ST_FILL;
            end
         end
         default: w_next_state = ST_FILL;
      endcase
   end

   // Counter wraps to zero on the last sample because N_SAMPLES is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_FILL;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_recv_fire) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   fft_frame_buffer #(
      .BIT_WIDTH (BIT_WIDTH),
      .N_SAMPLES (N_SAMPLES),
      .ADDR_W    (CNT_W)
   ) u_buf (
      .clk     (clk),
      .i_clr_n (reset),
      .i_we    (w_recv_fire),
      .i_waddr (w_waddr),
      .i_wdata (w_conv),
      .o_rdata (send_msg_real)
   );

   always_comb begin
      for (int i = 0; i < N_SAMPLES; i++) begin
         send_msg_imag[i] = '0;
      end
   end

   assign o_dbg_state = r_state;
   assign o_dbg_cnt   = r_cnt;

endmodule
